// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I load/store constants and LSU state type
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, load extension and access legality
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] write_data,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic        load_fault,
  output logic        store_fault
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        misalign;

  assign sel_byte = raw_word[{addr_lo, 3'b000} +: 8];
  assign sel_half = raw_word[{addr_lo[1], 4'b0000} +: 16];

  // Size is encoded in funct3[1:0] for both loads and stores
  assign misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

  always_comb begin
    byte_en     = 4'b0000;
    store_data  = write_data;
    store_fault = 1'b0;
    case (funct3)
      F3_SB: begin
        byte_en    = 4'b0001 << addr_lo;
        store_data = {4{write_data[7:0]}};
      end
      F3_SH: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{write_data[15:0]}};
      end
      F3_SW:   byte_en = 4'b1111;
      default: store_fault = 1'b1;
    endcase
    store_fault = store_fault | misalign;
  end

  always_comb begin
    load_value = '0;
    load_fault = 1'b0;
    case (funct3)
      F3_LB:   load_value = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   load_value = {{16{sel_half[15]}}, sel_half};
      F3_LW:   load_value = raw_word;
      F3_LBU:  load_value = {24'h000000, sel_byte};
      F3_LHU:  load_value = {16'h0000, sel_half};
      default: load_fault = 1'b1;
    endcase
    load_fault = load_fault | misalign;
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - data-memory stage: word array, load FSM and read_data register
module data_mem_lsu
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        access_fault
);

  logic [31:0]      mem [DEPTH_WORDS];
  lsu_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic [31:0]      raw_word;
  logic [3:0]       byte_en;
  logic [31:0]      store_data;
  logic [31:0]      load_value;
  logic             load_fault, store_fault, fault;
  logic             store_go, load_go;
  logic             unused_addr_bits;

  // High address bits are dropped so the array aliases across the address space
  assign idx              = addr[IDX_W+1:2];
  assign unused_addr_bits = ^addr[31:IDX_W+2];
  assign raw_word         = mem[idx];

  lsu_align u_align (
    .funct3      (funct3),
    .addr_lo     (addr[1:0]),
    .write_data  (write_data),
    .raw_word    (raw_word),
    .byte_en     (byte_en),
    .store_data  (store_data),
    .load_value  (load_value),
    .load_fault  (load_fault),
    .store_fault (store_fault)
  );

  // A request with both strobes is judged purely as a store
  assign fault        = mem_write ? store_fault : (mem_read & load_fault);
  assign access_fault = fault & ~reset;
  assign stall        = load_go & ~reset;

  always_comb begin
    state_d  = state_q;
    store_go = 1'b0;
    load_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          store_go = ~fault;
        end else if (mem_read && !fault) begin
          load_go = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else if (load_go) begin
      read_data <= load_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (store_go) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - randomized self-checking bench for data_mem_lsu
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data;
  logic [31:0] read_data;
  logic        stall, access_fault;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rd;

  data_mem_lsu dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .stall        (stall),
    .access_fault (access_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    int sz;
    if (!rd && !wr) return 1'b0;
    if (wr) begin
      if (f3 > 3'd2) return 1'b1;
    end else if (f3 == 3'd3 || f3 > 3'd5) begin
      return 1'b1;
    end
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int     ba, n;
    longint v;
    ba = int'(a % 256);
    n  = 1 << f3[1:0];
    v  = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[ba + i]) << (8 * i);
    if (f3 < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int ba, n;
    logic [31:0] w;
    ba = int'(a % 256);
    n  = 1 << f3[1:0];
    w  = wd;
    for (int i = 0; i < n; i++) begin
      ref_mem[ba + i] = w[7:0];
      w = w >> 8;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    exp_rd = '0;
  endtask

  task automatic op(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd);
    bit f, ld;
    logic [31:0] lv;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; write_data = wd;
    #1;
    f  = m_fault(rd, wr, f3, a);
    ld = rd && !wr && !f;
    lv = ld ? m_load(f3, a) : exp_rd;
    check({tag, "_fault"}, 32'(access_fault), 32'(f));
    check({tag, "_stall"}, 32'(stall), 32'(ld));
    @(posedge clk); #1;
    if (wr && !f) m_store(f3, a, wd);
    if (ld) begin
      exp_rd = lv;
      @(negedge clk);
      check({tag, "_resp_stall"}, 32'(stall), 32'd0);
      check({tag, "_rdata"}, read_data, exp_rd);
      @(posedge clk); #1;
    end else begin
      check({tag, "_hold"}, read_data, exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] lv;
    int kind;
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b011; addr = 32'h11; write_data = '0;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", read_data, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fault", 32'(access_fault), 32'd0);
    mem_read = 1'b0;
    reset = 1'b0;

    op("t1_lw0", 1, 0, 3'b010, 32'h00, 0);
    check("t1_val", read_data, 32'h0);

    op("t2_sw",  0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    op("t2_lw",  1, 0, 3'b010, 32'h10, 0); check("t2_lw_c",  read_data, 32'hDEADBEEF);
    op("t2_lb",  1, 0, 3'b000, 32'h13, 0); check("t2_lb_c",  read_data, 32'hFFFFFFDE);
    op("t2_lbu", 1, 0, 3'b100, 32'h13, 0); check("t2_lbu_c", read_data, 32'h000000DE);
    op("t2_lh",  1, 0, 3'b001, 32'h12, 0); check("t2_lh_c",  read_data, 32'hFFFFDEAD);
    op("t2_lhu", 1, 0, 3'b101, 32'h10, 0); check("t2_lhu_c", read_data, 32'h0000BEEF);

    op("t3_sb",  0, 1, 3'b000, 32'h11, 32'h55);
    op("t3_lw1", 1, 0, 3'b010, 32'h10, 0); check("t3_lw1_c", read_data, 32'hDEAD55EF);
    op("t3_sh",  0, 1, 3'b001, 32'h12, 32'h1234);
    op("t3_lw2", 1, 0, 3'b010, 32'h10, 0); check("t3_lw2_c", read_data, 32'h123455EF);

    op("t4_lwmis", 1, 0, 3'b010, 32'h12, 0);
    op("t4_shmis", 0, 1, 3'b001, 32'h11, 32'hFFFF);
    op("t4_lw",    1, 0, 3'b010, 32'h10, 0); check("t4_lw_c", read_data, 32'h123455EF);
    op("t4_f3",    1, 0, 3'b011, 32'h10, 0);
    op("t4_both",  1, 1, 3'b010, 32'h18, 32'hCAFEF00D);
    op("t4_lwb",   1, 0, 3'b010, 32'h18, 0); check("t4_lwb_c", read_data, 32'hCAFEF00D);

    // back-to-back loads with mem_read held high throughout
    op("t5_sw14", 0, 1, 3'b010, 32'h14, 32'h0BADF00D);
    @(negedge clk);
    mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h10; #1;
    check("b2b_s1", 32'(stall), 32'd1);
    lv = m_load(3'b010, 32'h10);
    @(posedge clk); #1; exp_rd = lv;
    @(negedge clk); addr = 32'h14; #1;
    check("b2b_s2", 32'(stall), 32'd0);
    check("b2b_d1", read_data, exp_rd);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("b2b_s3", 32'(stall), 32'd1);
    lv = m_load(3'b010, 32'h14);
    @(posedge clk); #1; exp_rd = lv;
    @(negedge clk); #1;
    check("b2b_s4", 32'(stall), 32'd0);
    check("b2b_d2", read_data, 32'h0BADF00D);
    @(posedge clk); #1;

    op("t5_alias_sw", 0, 1, 3'b010, 32'h100, 32'hA5A5A5A5);
    op("t5_alias_lw", 1, 0, 3'b010, 32'h000, 0); check("t5_alias_c", read_data, 32'hA5A5A5A5);

    // a store presented during RESP must be dropped
    @(negedge clk);
    mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h20; #1;
    lv = m_load(3'b010, 32'h20);
    @(posedge clk); #1; exp_rd = lv;
    @(negedge clk);
    mem_read = 0; mem_write = 1; write_data = 32'hFFFFFFFF; #1;
    check("resp_st_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    op("resp_st_lw", 1, 0, 3'b010, 32'h20, 0);

    // reset landing in the RESP cycle of a load
    @(negedge clk);
    mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h10; #1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1; #1;
    check("t6_stall", 32'(stall), 32'd0);
    check("t6_rdata", read_data, 32'd0);
    m_clear();
    mem_read = 0;
    @(negedge clk);
    reset = 1'b0;
    op("t6_lw", 1, 0, 3'b010, 32'h10, 0); check("t6_lw_c", read_data, 32'h0);

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      op("rnd", kind[0], kind[1], 3'($urandom_range(0, 7)),
         {$urandom_range(0, 15), 20'h0, 8'($urandom)}, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
